// File: rtl/ac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ac_pkg
//  Description : Shared definitions for the Autoconfig host enumerator.
//                Holds the config page address, register offsets, FSM state
//                encodings and the size-code decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package ac_pkg;

    // A23:A16 of the Autoconfig page
    localparam logic [7:0] E8_PAGE = 8'hE8;

    // Register offsets on A6:A1
    localparam logic [5:0] ER_TYPE = 6'h00;   // $00 type nibble
    localparam logic [5:0] ER_SIZE = 6'h01;   // $02 size nibble
    localparam logic [5:0] BASE_HI = 6'h24;   // $48 base A23:A20, configures
    localparam logic [5:0] BASE_LO = 6'h25;   // $4A base A19:A16
    localparam logic [5:0] SHUTUP  = 6'h26;   // $4C shut-up

    // Enumeration FSM
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_TYPE = 3'd1,
        ST_RD_SIZE = 3'd2,
        ST_ALLOC   = 3'd3,
        ST_WR_LO   = 3'd4,
        ST_WR_HI   = 3'd5,
        ST_WR_SHUT = 3'd6,
        ST_DONE    = 3'd7
    } ac_state_e;

    // Bus-cycle sequencer
    typedef enum logic [2:0] {
        BC_IDLE    = 3'd0,
        BC_SETUP   = 3'd1,
        BC_STROBE  = 3'd2,
        BC_WAIT    = 3'd3,
        BC_RELEASE = 3'd4
    } bc_state_e;

    // Size code (D_i[2:0] from $02, not inverted) to 64KB units
    function automatic logic [8:0] size_units(input logic [2:0] code);
        logic [8:0] units;
        case (code)
            3'b000:  units = 9'd128;
            3'b001:  units = 9'd1;
            3'b010:  units = 9'd2;
            3'b011:  units = 9'd4;
            3'b100:  units = 9'd8;
            3'b101:  units = 9'd16;
            3'b110:  units = 9'd32;
            default: units = 9'd64;
        endcase
        return units;
    endfunction

endpackage
`default_nettype wire

// File: rtl/autoconfig_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : autoconfig_host_if
//  Description : Zorro II expansion-bus signals seen by the Autoconfig host.
//                master : host side (drives address, strobe, write data,
//                         _configout; receives D_i and DTACK)
//                slave  : board/responder side
//  Revision    : 1.0  initial release
// ============================================================================
interface autoconfig_host_if;
    logic [7:0] AH;          // A23:A16
    logic [5:0] AL;          // A6:A1
    logic       RW;          // 1=read, 0=write
    logic       _UDS;        // upper data strobe, active low
    logic [3:0] D_o;         // write data D15:D12
    logic       data_oe;     // D_o drive enable
    logic [3:0] D_i;         // read data D15:D12
    logic       DTACK;       // cycle acknowledge, positive logic
    logic       _configout;  // first board's _CONFIG_IN

    modport master (
        output AH, AL, RW, _UDS, D_o, data_oe, _configout,
        input  D_i, DTACK
    );

    modport slave (
        input  AH, AL, RW, _UDS, D_o, data_oe, _configout,
        output D_i, DTACK
    );
endinterface
`default_nettype wire

// File: rtl/autoconfig_bus_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : autoconfig_bus_cycle
//  Description : Runs one config-page bus cycle:
//                SETUP -> STROBE -> WAIT (>=2 clk) -> RELEASE -> IDLE.
//                Ports: CLK, _RST (async active low); req/rw/al/wdata start
//                a cycle; ack or timeout pulse for one clock at its end,
//                rdata holds the sampled D_i; bus = host-side bus signals
//                (_configout is left to the parent).
//  Revision    : 1.0  initial release
// ============================================================================
module autoconfig_bus_cycle
    import ac_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  wire logic        CLK,
    input  wire logic        _RST,
    input  wire logic        req,
    input  wire logic        rw,
    input  wire logic [5:0]  al,
    input  wire logic [3:0]  wdata,
    output logic             ack,
    output logic             timeout,
    output logic [3:0]       rdata,
    autoconfig_host_if.master bus
);

    localparam int TW = $clog2(TIMEOUT + 1);

    bc_state_e       state_q, state_d;
    logic [7:0]      ah_q, ah_d;
    logic [5:0]      al_q, al_d;
    logic            rw_q, rw_d;
    logic            uds_n_q, uds_n_d;
    logic [3:0]      do_q, do_d;
    logic            oe_q, oe_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;     // clocks since STROBE
    logic            to_q, to_d;         // current cycle ended by timeout
    logic [3:0]      rdata_q, rdata_d;
    logic            ack_q, ack_d;
    logic            timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        ah_d      = ah_q;
        al_d      = al_q;
        rw_d      = rw_q;
        uds_n_d   = uds_n_q;
        do_d      = do_q;
        oe_d      = oe_q;
        tcnt_d    = tcnt_q;
        to_d      = to_q;
        rdata_d   = rdata_q;
        ack_d     = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            BC_IDLE: begin
                if (req) begin
                    ah_d    = E8_PAGE;
                    al_d    = al;
                    rw_d    = rw;
                    do_d    = wdata;
                    oe_d    = ~rw;
                    state_d = BC_SETUP;
                end
            end
            BC_SETUP: begin
                uds_n_d = 1'b0;
                tcnt_d  = '0;
                state_d = BC_STROBE;
            end
            BC_STROBE: begin
                tcnt_d  = tcnt_q + TW'(1);
                state_d = BC_WAIT;
            end
            BC_WAIT: begin
                // DTACK is only honoured from the second WAIT clock on,
                // which keeps the strobe low for at least two WAIT clocks.
                if ((tcnt_q >= TW'(2)) && bus.DTACK) begin
                    rdata_d = bus.D_i;
                    uds_n_d = 1'b1;
                    to_d    = 1'b0;
                    state_d = BC_RELEASE;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    uds_n_d = 1'b1;
                    to_d    = 1'b1;
                    state_d = BC_RELEASE;
                end else begin
                    tcnt_d  = tcnt_q + TW'(1);
                end
            end
            BC_RELEASE: begin
                rw_d      = 1'b1;
                oe_d      = 1'b0;
                ack_d     = ~to_q;
                timeout_d = to_q;
                state_d   = BC_IDLE;
            end
            default: begin
                state_d = BC_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state_q   <= BC_IDLE;
            ah_q      <= '0;
            al_q      <= '0;
            rw_q      <= 1'b1;
            uds_n_q   <= 1'b1;
            do_q      <= '0;
            oe_q      <= 1'b0;
            tcnt_q    <= '0;
            to_q      <= 1'b0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ah_q      <= ah_d;
            al_q      <= al_d;
            rw_q      <= rw_d;
            uds_n_q   <= uds_n_d;
            do_q      <= do_d;
            oe_q      <= oe_d;
            tcnt_q    <= tcnt_d;
            to_q      <= to_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.AH      = ah_q;
    assign bus.AL      = al_q;
    assign bus.RW      = rw_q;
    assign bus._UDS    = uds_n_q;
    assign bus.D_o     = do_q;
    assign bus.data_oe = oe_q;
    assign ack         = ack_q;
    assign timeout     = timeout_q;
    assign rdata       = rdata_q;

endmodule
`default_nettype wire

// File: rtl/autoconfig_host.sv
`default_nettype none
// ============================================================================
//  Module      : autoconfig_host
//  Description : Host-side Autoconfig enumerator for Zorro II boards.
//                Walks the _CONFIG chain, reads type/size of each board,
//                assigns a naturally aligned base from the memory pool or
//                shuts the board up when the pool cannot hold it.
//                Ports: CLK, _RST (async active low); start (1-clk pulse);
//                busy, done, board_count, shut_count status;
//                bus = expansion-bus signals (master side).
//  Revision    : 1.0  initial release
// ============================================================================
module autoconfig_host
    import ac_pkg::*;
#(
    parameter int         TIMEOUT    = 16,
    parameter logic [7:0] POOL_BASE  = 8'h20,
    parameter logic [8:0] POOL_TOP   = 9'h0A0,
    parameter int         MAX_BOARDS = 8
) (
    input  wire logic        CLK,
    input  wire logic        _RST,
    input  wire logic        start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       board_count,
    output logic [3:0]       shut_count,
    autoconfig_host_if.master bus
);

    ac_state_e   state_q, state_d;
    logic        req_q, req_d;
    logic        rw_q, rw_d;
    logic [5:0]  al_q, al_d;
    logic [3:0]  wdata_q, wdata_d;
    logic [8:0]  next_free_q, next_free_d;
    logic [8:0]  base_q, base_d;
    logic [8:0]  size_q, size_d;
    logic [3:0]  board_count_q, board_count_d;
    logic [3:0]  shut_count_q, shut_count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        configout_n_q, configout_n_d;

    logic        bc_ack;
    logic        bc_timeout;
    logic [3:0]  bc_rdata;

    autoconfig_bus_cycle #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_cycle (
        .CLK     (CLK),
        ._RST    (_RST),
        .req     (req_q),
        .rw      (rw_q),
        .al      (al_q),
        .wdata   (wdata_q),
        .ack     (bc_ack),
        .timeout (bc_timeout),
        .rdata   (bc_rdata),
        .bus     (bus)
    );

    // Allocator: round next_free up to a multiple of the (power-of-two) size.
    // 9-bit arithmetic cannot wrap here; anything at or above 9'h100 is
    // outside the pool and is shut up.
    logic [8:0] w_base;
    logic [8:0] w_end;
    logic       w_fits;
    logic [4:0] w_seen;
    logic       w_last;

    assign w_base = (next_free_q + size_q - 9'd1) & ~(size_q - 9'd1);
    assign w_end  = w_base + size_q;
    assign w_fits = ~w_base[8] && (w_end <= POOL_TOP);
    // Boards handled including the one whose final write just completed
    assign w_seen = {1'b0, board_count_q} + {1'b0, shut_count_q} + 5'd1;
    assign w_last = (w_seen >= 5'(MAX_BOARDS));

    always_comb begin
        state_d       = state_q;
        req_d         = 1'b0;
        rw_d          = rw_q;
        al_d          = al_q;
        wdata_d       = wdata_q;
        next_free_d   = next_free_q;
        base_d        = base_q;
        size_d        = size_q;
        board_count_d = board_count_q;
        shut_count_d  = shut_count_q;
        configout_n_d = configout_n_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    board_count_d = '0;
                    shut_count_d  = '0;
                    next_free_d   = {1'b0, POOL_BASE};
                    configout_n_d = 1'b0;
                    req_d         = 1'b1;
                    rw_d          = 1'b1;
                    al_d          = ER_TYPE;
                    wdata_d       = '0;
                    state_d       = ST_RD_TYPE;
                end
            end
            ST_RD_TYPE: begin
                if (bc_timeout) begin
                    state_d = ST_DONE;
                end else if (bc_ack) begin
                    if (bc_rdata[3:2] != 2'b11) begin
                        state_d = ST_DONE;
                    end else begin
                        req_d   = 1'b1;
                        rw_d    = 1'b1;
                        al_d    = ER_SIZE;
                        wdata_d = '0;
                        state_d = ST_RD_SIZE;
                    end
                end
            end
            ST_RD_SIZE: begin
                if (bc_timeout) begin
                    state_d = ST_DONE;
                end else if (bc_ack) begin
                    size_d  = size_units(bc_rdata[2:0]);
                    state_d = ST_ALLOC;
                end
            end
            ST_ALLOC: begin
                req_d = 1'b1;
                rw_d  = 1'b0;
                if (w_fits) begin
                    base_d  = w_base;
                    al_d    = BASE_LO;
                    wdata_d = w_base[3:0];
                    state_d = ST_WR_LO;
                end else begin
                    al_d    = SHUTUP;
                    wdata_d = '0;
                    state_d = ST_WR_SHUT;
                end
            end
            ST_WR_LO: begin
                if (bc_timeout) begin
                    state_d = ST_DONE;
                end else if (bc_ack) begin
                    // The $48 write configures the board, so it goes last
                    req_d   = 1'b1;
                    rw_d    = 1'b0;
                    al_d    = BASE_HI;
                    wdata_d = base_q[7:4];
                    state_d = ST_WR_HI;
                end
            end
            ST_WR_HI, ST_WR_SHUT: begin
                if (bc_timeout) begin
                    state_d = ST_DONE;
                end else if (bc_ack) begin
                    if (state_q == ST_WR_HI) begin
                        next_free_d   = base_q + size_q;
                        board_count_d = board_count_q + 4'd1;
                    end else begin
                        shut_count_d  = shut_count_q + 4'd1;
                    end
                    if (w_last) begin
                        state_d = ST_DONE;
                    end else begin
                        req_d   = 1'b1;
                        rw_d    = 1'b1;
                        al_d    = ER_TYPE;
                        wdata_d = '0;
                        state_d = ST_RD_TYPE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state_q       <= ST_IDLE;
            req_q         <= 1'b0;
            rw_q          <= 1'b1;
            al_q          <= '0;
            wdata_q       <= '0;
            next_free_q   <= {1'b0, POOL_BASE};
            base_q        <= '0;
            size_q        <= '0;
            board_count_q <= '0;
            shut_count_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            configout_n_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            rw_q          <= rw_d;
            al_q          <= al_d;
            wdata_q       <= wdata_d;
            next_free_q   <= next_free_d;
            base_q        <= base_d;
            size_q        <= size_d;
            board_count_q <= board_count_d;
            shut_count_q  <= shut_count_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            configout_n_q <= configout_n_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign board_count    = board_count_q;
    assign shut_count     = shut_count_q;
    assign bus._configout = configout_n_q;

endmodule
`default_nettype wire

// File: tb/tb_autoconfig_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_autoconfig_host
//  Description : Scoreboard bench for autoconfig_host with a chain of
//                Zorro II responder models on the config page.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_autoconfig_host;
    import ac_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int NB      = 9;

    logic       CLK   = 1'b0;
    logic       _RST  = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] board_count;
    logic [3:0] shut_count;

    autoconfig_host_if bus();

    autoconfig_host #(
        .TIMEOUT    (TIMEOUT),
        .POOL_BASE  (8'h20),
        .POOL_TOP   (9'h0A0),
        .MAX_BOARDS (8)
    ) dut (
        .CLK         (CLK),
        ._RST        (_RST),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .board_count (board_count),
        .shut_count  (shut_count),
        .bus         (bus)
    );

    always #5 CLK = ~CLK;

    // ---------------- responder chain ----------------
    logic       brd_present [NB];
    logic [3:0] brd_type    [NB];
    logic [3:0] brd_size    [NB];
    logic       brd_cfg     [NB];
    logic       brd_shut    [NB];
    logic [7:0] brd_base    [NB];
    logic [3:0] brd_lo      [NB];
    logic       brd_clr = 1'b0;
    int         act;
    logic       chain;
    logic       resp_dtack;
    logic [3:0] resp_d;
    logic       prev_uds_b = 1'b1;

    always_comb begin
        act   = -1;
        chain = (bus._configout == 1'b0);
        for (int i = 0; i < NB; i++) begin
            if (!brd_present[i]) begin
                chain = 1'b0;
            end else if (chain && !brd_cfg[i] && !brd_shut[i]) begin
                act   = i;
                chain = 1'b0;
            end
        end
        resp_dtack = 1'b0;
        resp_d     = 4'h0;
        if (act >= 0 && bus.AH == 8'hE8 && !bus._UDS) begin
            resp_dtack = 1'b1;
            if (bus.AL == ER_TYPE)      resp_d = brd_type[act];
            else if (bus.AL == ER_SIZE) resp_d = brd_size[act];
        end
    end

    assign bus.D_i   = resp_d;
    assign bus.DTACK = resp_dtack;

    always @(negedge CLK) begin
        if (!_RST || brd_clr) begin
            for (int i = 0; i < NB; i++) begin
                brd_cfg[i]  <= 1'b0;
                brd_shut[i] <= 1'b0;
                brd_base[i] <= 8'h00;
                brd_lo[i]   <= 4'h0;
            end
        end else if (!prev_uds_b && bus._UDS && !bus.RW && bus.AH == 8'hE8 && act >= 0) begin
            case (bus.AL)
                BASE_LO: brd_lo[act] <= bus.D_o;
                BASE_HI: begin
                    brd_base[act] <= {bus.D_o, brd_lo[act]};
                    brd_cfg[act]  <= 1'b1;
                end
                SHUTUP:  brd_shut[act] <= 1'b1;
                default: ;
            endcase
        end
        prev_uds_b <= bus._UDS;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [127:0] name;
        int           act;
        int           exp;
        bit           le;
    } chk_t;

    logic [9:0] exp_wr_q  [$];
    logic [7:0] exp_res_q [$];
    chk_t       chk_q     [$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic       prev_uds_m  = 1'b1;
    logic       prev_done_m = 1'b0;

    always @(negedge CLK) begin
        logic [9:0] ew;
        logic [7:0] er;
        chk_t       c;
        bit         ok;
        if (_RST && !prev_uds_m && bus._UDS && !bus.RW) begin
            n_cmp++;
            if (exp_wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: got AL=%h D=%h, required no write", bus.AL, bus.D_o);
            end else begin
                ew = exp_wr_q.pop_front();
                if ({bus.AL, bus.D_o} !== ew) begin
                    n_fail++;
                    $display("FAIL wr_data: got AL=%h D=%h, required AL=%h D=%h",
                             bus.AL, bus.D_o, ew[9:4], ew[3:0]);
                end
            end
        end
        if (_RST && done && !prev_done_m) begin
            n_cmp++;
            if (exp_res_q.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected: got boards=%0d shut=%0d, required no done",
                         board_count, shut_count);
            end else begin
                er = exp_res_q.pop_front();
                if ({board_count, shut_count} !== er) begin
                    n_fail++;
                    $display("FAIL counts: got boards=%0d shut=%0d, required boards=%0d shut=%0d",
                             board_count, shut_count, er[7:4], er[3:0]);
                end
            end
        end
        while (chk_q.size() > 0) begin
            c  = chk_q.pop_front();
            ok = c.le ? (c.act <= c.exp) : (c.act == c.exp);
            n_cmp++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %0s: got %0d, required %s%0d", c.name, c.act, c.le ? "<=" : "==", c.exp);
            end
        end
        prev_uds_m  <= bus._UDS;
        prev_done_m <= done;
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input logic [127:0] nm, input int a, input int e);
        chk_q.push_back('{name: nm, act: a, exp: e, le: 1'b0});
    endtask

    task automatic chk_le(input logic [127:0] nm, input int a, input int e);
        chk_q.push_back('{name: nm, act: a, exp: e, le: 1'b1});
    endtask

    task automatic push_wr(input logic [5:0] al, input logic [3:0] d);
        exp_wr_q.push_back({al, d});
    endtask

    task automatic push_res(input logic [3:0] bc, input logic [3:0] sc);
        exp_res_q.push_back({bc, sc});
    endtask

    task automatic clear_boards();
        for (int i = 0; i < NB; i++) begin
            brd_present[i] = 1'b0;
            brd_type[i]    = 4'h0;
            brd_size[i]    = 4'h0;
        end
        brd_clr = 1'b1;
        repeat (2) @(negedge CLK);
        brd_clr = 1'b0;
    endtask

    task automatic add_board(input int i, input logic [3:0] t, input logic [3:0] s);
        brd_present[i] = 1'b1;
        brd_type[i]    = t;
        brd_size[i]    = s;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            @(negedge CLK);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
        repeat (2) @(negedge CLK);
        chk("wr_left", exp_wr_q.size(), 0);
        chk("res_left", exp_res_q.size(), 0);
    endtask

    task automatic run(input int max, output int n);
        pulse_start();
        wait_done(max, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, required end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int k;
        for (int i = 0; i < NB; i++) begin
            brd_present[i] = 1'b0;
            brd_type[i]    = 4'h0;
            brd_size[i]    = 4'h0;
        end
        repeat (3) @(negedge CLK);

        // Reset state
        chk("rst_uds", bus._UDS, 1);
        chk("rst_rw", bus.RW, 1);
        chk("rst_oe", bus.data_oe, 0);
        chk("rst_ah", bus.AH, 0);
        chk("rst_al", bus.AL, 0);
        chk("rst_do", bus.D_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bcount", board_count, 0);
        chk("rst_scount", shut_count, 0);
        chk("rst_cfgout", bus._configout, 1);
        _RST = 1'b1;
        @(negedge CLK);

        // One 2MB board
        clear_boards();
        add_board(0, 4'hE, 4'h6);
        push_wr(BASE_LO, 4'h0); push_wr(BASE_HI, 4'h2);
        push_res(4'd1, 4'd0);
        pulse_start();
        chk("t1_busy", busy, 1);
        chk("t1_cfgout", bus._configout, 0);
        wait_done(400, n);
        chk("t1_cfg", brd_cfg[0], 1);
        chk("t1_base_a23_21", brd_base[0][7:5], 1);

        // Two chained 2MB boards; a start while busy must be ignored
        clear_boards();
        add_board(0, 4'hE, 4'h6);
        add_board(1, 4'hE, 4'h6);
        push_wr(BASE_LO, 4'h0); push_wr(BASE_HI, 4'h2);
        push_wr(BASE_LO, 4'h0); push_wr(BASE_HI, 4'h4);
        push_res(4'd2, 4'd0);
        pulse_start();
        repeat (4) @(negedge CLK);
        pulse_start();
        wait_done(400, n);
        chk("t2_base0", brd_base[0], 8'h20);
        chk("t2_base1", brd_base[1], 8'h40);

        // 1MB board moves next_free to $30; a 2MB board then aligns to $40
        clear_boards();
        add_board(0, 4'hE, 4'h5);
        add_board(1, 4'hE, 4'h6);
        push_wr(BASE_LO, 4'h0); push_wr(BASE_HI, 4'h2);
        push_wr(BASE_LO, 4'h0); push_wr(BASE_HI, 4'h4);
        push_res(4'd2, 4'd0);
        run(400, n);
        chk("t3_base1", brd_base[1], 8'h40);

        // 8MB board: aligned $80 + $80 exceeds $A0 -> shut up
        clear_boards();
        add_board(0, 4'hE, 4'h0);
        push_wr(SHUTUP, 4'h0);
        push_res(4'd0, 4'd1);
        run(400, n);
        chk("t4_shut", brd_shut[0], 1);
        chk("t4_not_cfg", brd_cfg[0], 0);

        // No board at all
        clear_boards();
        push_res(4'd0, 4'd0);
        run(400, n);
        chk_le("nb_latency", n + 1, TIMEOUT + 8);

        // Non-Zorro-II type ends enumeration with no writes
        clear_boards();
        add_board(0, 4'h8, 4'h6);
        push_res(4'd0, 4'd0);
        run(400, n);
        chk("t6_not_cfg", brd_cfg[0], 0);

        // Nine 64KB boards: only eight are handled
        clear_boards();
        for (int i = 0; i < NB; i++) add_board(i, 4'hE, 4'h1);
        for (int i = 0; i < 8; i++) begin
            push_wr(BASE_LO, 4'(i));
            push_wr(BASE_HI, 4'h2);
        end
        push_res(4'd8, 4'd0);
        run(2000, n);
        chk("t7_base7", brd_base[7], 8'h27);
        chk("t7_ninth_idle", brd_cfg[8], 0);

        // Asynchronous reset while _UDS is low, then re-enumerate
        clear_boards();
        add_board(0, 4'hE, 4'h6);
        pulse_start();
        k = 0;
        while (bus._UDS && k < 20) begin
            @(negedge CLK);
            k++;
        end
        chk("t8_uds_low_seen", bus._UDS, 0);
        #2;
        _RST = 1'b0;
        #1;
        chk("t8_uds_async", bus._UDS, 1);
        chk("t8_busy", busy, 0);
        chk("t8_cfgout", bus._configout, 1);
        repeat (2) @(negedge CLK);
        _RST = 1'b1;
        @(negedge CLK);
        push_wr(BASE_LO, 4'h0); push_wr(BASE_HI, 4'h2);
        push_res(4'd1, 4'd0);
        run(400, n);
        chk("t8_base", brd_base[0], 8'h20);

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
